accu_serial_tx: RTL
===================

# accu_serial_tx

Serial output transmitter for the KMA_CPU. It reads the accumulator word and its carry flag on a write strobe and shifts them out on a single-wire line. Each frame carries a start bit, the data bits LSB first, the carry, an even-parity bit and a stop bit. A one-entry holding buffer lets the CPU queue the next word while the current frame is still on the line, so frames can go out back-to-back.

## Interface
- `data_width`, default `` `data_width `` (global defines file): width of the accumulator word sent per frame.
- `clk_div`, default 4: clock cycles per serial bit; minimum 2.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset. **Asynchronous, active-high.** One clock domain only.
- `ce`  in  1  clock enable. While low, all state freezes, including `wr` acceptance, the counters, the FSM and every output.
- `data_in`  in  `data_width`  signed accumulator value to send.
- `cy_i`  in  1  carry flag sent with the word.
- `wr`  in  1  write strobe. Sampled only when `ce`=1.
- `ready`  out  1  holding buffer empty, so `wr` will be accepted.
- `busy`  out  1  a frame is on the line (FSM not IDLE).
- `ovf`  out  1  sticky overrun flag: a `wr` arrived while `ready`=0.
- `tx`  out  1  serial line, registered; idles high.

## Operation
- **Frame format**, `data_width`+4 bits: start (0), `data_in[0]` … `data_in[data_width-1]`, carry, parity, stop (1).
  - Parity = XOR of all data bits and the carry, so the data + carry + parity ones count is even.
- **Holding buffer**, {cy, data}, valid flag `hv`.
  - `ready` = !`hv`, driven from the register.
  - `wr`=1 with `ce`=1 and `ready`=1: capture `data_in`, `cy_i`; set `hv`.
  - `wr`=1 with `ready`=0: input ignored, buffer unchanged, `ovf`←1. `ovf` is cleared only by `rst`.
- **FSM states:** IDLE, START, DATA, CARRY, PARITY, STOP.
  - IDLE, `hv`=1: load the shifter from the buffer, clear `hv`, go to START.
  - START → DATA after `clk_div` cycles.
  - DATA: shift one bit per `clk_div` cycles; bit index runs 0..`data_width`-1, then go to CARRY.
  - CARRY → PARITY → STOP, `clk_div` cycles each.
  - STOP end, `hv`=1: load the shifter, clear `hv`, go to START. No idle bit is inserted.
  - STOP end, `hv`=0: go to IDLE.
- Parity is computed at shifter load and held in the shifter. Later buffer writes do not affect the frame in flight.
- Signed data is sent as its raw two's-complement bits. No sign extension or other transformation is applied.

## Timing
- **Reset values:** `tx`=1, `ready`=1, `busy`=0, `ovf`=0; FSM IDLE; `hv`=0; bit and cycle counters 0.
- **Reset mid-frame:** `tx` returns to 1 immediately (asynchronous). The frame is abandoned and the buffered word is discarded.
- **Write latency from idle:**
  - `wr` accepted at edge N: `ready`=0 after N.
  - Edge N+1: shifter loaded, `hv` cleared, `tx`=0, `busy`=1, `ready`=1.
- **Bit timing:** every bit level holds for exactly `clk_div` edges with `ce`=1. Cycles with `ce`=0 stretch the current bit and do not count.
- **Frame length:** (`data_width`+4)·`clk_div` ce-active cycles. With `data_width`=8 and `clk_div`=4 this is 48.
- **Frame end, next word queued:** the edge that ends STOP with `hv`=1 drives `tx`=0 (start of next frame) and `ready`=1.
- **Frame end, nothing queued:** the edge that ends STOP with `hv`=0 drives `busy`=0; `tx` stays 1.
- **`wr` on the edge STOP ends with `hv`=0:** the word is captured. FSM enters IDLE for one cycle; the next edge starts the frame, giving one idle cycle.
- **`wr` with `ready`=0 on the edge that empties the buffer:** ignored and sets `ovf`. `ready` is sampled as registered before that edge.

## Test plan
All cases run with `data_width`=8, `clk_div`=4.
- **Single frame:** `wr` with `data_in`=8'hA5, `cy_i`=1 from idle → `tx` sequence, 4 cycles per bit: 0; 1,0,1,0,0,1,0,1; 1; 1; 1. `busy` high for 48 cycles, then 0.
- **Negative value:** `data_in`=-1 (8'hFF), `cy_i`=0 → data bits all 1, carry 0, parity 0.
- **Back-to-back:** `wr` 8'h12 (cy 0), then `wr` 8'h34 (cy 1) 10 cycles later.
  - `ready` drops after the second `wr` and rises exactly 48 cycles after the first frame's start.
  - The second start bit directly follows the first stop bit with no gap; parity of the second frame = 0.
- **Overrun:** with a word already queued, a third `wr` 8'h56 → `ovf`=1 and stays 1. Only two frames are sent.
- **Clock enable:** `ce` low for 5 cycles during data bit 3 → bit 3 lasts 9 cycles, frame lasts 53 cycles, contents unchanged.
- **Reset mid-frame:** assert `rst` during DATA → `tx`=1, `busy`=0, `ready`=1, `ovf`=0 without waiting for a clock edge. No frame resumes after `rst` is released.

Source files
------------

// File: rtl/accu_serial_tx_if.sv
// -----------------------------------------------------------------------------
// accu_serial_tx_if
//
// Bundles the CPU-facing write port and the serial-line side of the
// accumulator transmitter.
//
// Valid/ready contract for the write port: a word is transferred on a rising
// clk edge where ce=1, wr=1 and ready=1 (ready as registered before that
// edge). A wr seen with ce=1 and ready=0 moves no data and raises the
// sticky ovf flag. ready does not depend combinationally on wr.
//
// Signals
//   ce       clock enable. While low the transmitter is frozen.
//   data_in  signed accumulator word, sent as raw two's-complement bits.
//   cy_i     carry flag sent after the data bits.
//   wr       write strobe.
//   ready    holding buffer empty.
//   busy     a frame is on the line.
//   ovf      sticky overrun flag.
//   tx       serial line, idles high.
//
// Modports
//   master   the CPU / testbench side: drives ce, data_in, cy_i, wr.
//   slave    the transmitter side: drives ready, busy, ovf, tx.
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface accu_serial_tx_if #(
  parameter int data_width = `DATA_WIDTH
) ();

  logic                         ce;
  logic signed [data_width-1:0] data_in;
  logic                         cy_i;
  logic                         wr;
  logic                         ready;
  logic                         busy;
  logic                         ovf;
  logic                         tx;

  modport master (
    output ce,
    output data_in,
    output cy_i,
    output wr,
    input  ready,
    input  busy,
    input  ovf,
    input  tx
  );

  modport slave (
    input  ce,
    input  data_in,
    input  cy_i,
    input  wr,
    output ready,
    output busy,
    output ovf,
    output tx
  );

endinterface

// File: rtl/accu_serial_tx.sv
// -----------------------------------------------------------------------------
// accu_serial_tx
//
// Serial output transmitter for the KMA_CPU. On a write strobe the
// accumulator word and its carry flag are captured into a one-entry holding
// buffer. The transmitter FSM moves the buffered word into a shifter and
// sends a frame on the single-wire tx line:
//
//   start(0), data[0] .. data[data_width-1], carry, parity, stop(1)
//
// Parity is the XOR of all data bits and the carry, so the ones count over
// data + carry + parity is even. Each bit lasts clk_div ce-active cycles.
// Because the buffer is separate from the shifter, the CPU can queue the
// next word while a frame is still going out, and frames follow each other
// without an idle bit.
//
// Parameters
//   data_width  width of the accumulator word.
//   clk_div     ce-active clock cycles per serial bit, minimum 2.
//
// Ports
//   clk        system clock, rising edge.
//   rst        asynchronous, active-high reset.
//   bus        accu_serial_tx_if.slave: ce, data_in, cy_i, wr in;
//              ready, busy, ovf, tx out.
//   state_dbg  current FSM state encoding, for observation only.
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module accu_serial_tx #(
  parameter int data_width = `DATA_WIDTH,
  parameter int clk_div    = 4
) (
  input  logic               clk,
  input  logic               rst,
  accu_serial_tx_if.slave    bus,
  output logic [2:0]         state_dbg
);

  // ---------------------------------------------------------------------------
  // Local sizes
  // ---------------------------------------------------------------------------
  // The start bit is driven straight onto tx at load time, so the shifter
  // only has to hold what follows it: data, carry, parity and stop.
  localparam int FW = data_width + 3;
  localparam int CW = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam int BW = $clog2(data_width + 1);

  localparam logic [CW-1:0] CYC_LAST = CW'(clk_div - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(data_width - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    CARRY  = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                state;
  state_t                state_next;

  logic                  hv;        // holding buffer valid
  logic [data_width:0]   hold_q;    // {carry, data} waiting to be sent
  logic [FW-1:0]         shift_q;   // remaining frame bits, next bit in [0]
  logic [CW-1:0]         cyc_cnt;   // cycles spent in the current bit
  logic [BW-1:0]         bit_cnt;   // data bit index while in DATA
  logic                  tx_q;
  logic                  ovf_q;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic bit_end;
  logic load;
  logic accept;
  logic overrun;

  // The current bit has had its clk_div cycles once the counter reaches its
  // last value; the next ce-active edge moves to the following bit.
  assign bit_end = (state != IDLE) && (cyc_cnt == CYC_LAST);

  // A buffered word is moved into the shifter either from IDLE or on the
  // very edge the stop bit ends, which is what makes frames back-to-back.
  assign load = bus.ce && hv &&
                ((state == IDLE) || ((state == STOP) && bit_end));

  // Acceptance looks only at the registered hv, so a wr on the edge that
  // empties the buffer still counts as an overrun.
  assign accept  = bus.ce && bus.wr && !hv;
  assign overrun = bus.ce && bus.wr &&  hv;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (bus.ce) begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (hv) state_next = START;
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt == BIT_LAST)) state_next = CARRY;
      end
      CARRY: begin
        if (bit_end) state_next = PARITY;
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) state_next = hv ? START : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.busy  = (state != IDLE);
    bus.ready = !hv;
    bus.ovf   = ovf_q;
    bus.tx    = tx_q;
    state_dbg = state;
  end

  // ---------------------------------------------------------------------------
  // Holding buffer and overrun flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hv     <= 1'b0;
      hold_q <= '0;
      ovf_q  <= 1'b0;
    end else if (bus.ce) begin
      // load needs hv=1 and accept needs hv=0, so they never coincide.
      if (load) begin
        hv <= 1'b0;
      end else if (accept) begin
        hv     <= 1'b1;
        hold_q <= {bus.cy_i, bus.data_in};
      end
      if (overrun) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shifter, bit timing and line driver
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '1;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      tx_q    <= 1'b1;
    end else if (bus.ce) begin
      if (load) begin
        // Parity is frozen here; later buffer writes cannot alter this frame.
        shift_q <= {1'b1, ^hold_q, hold_q};
        cyc_cnt <= '0;
        bit_cnt <= '0;
        tx_q    <= 1'b0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          cyc_cnt <= '0;
          // Ones are shifted in so that the edge ending the stop bit with
          // nothing queued leaves the line high.
          tx_q    <= shift_q[0];
          shift_q <= {1'b1, shift_q[FW-1:1]};
          if (state == DATA) begin
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
          end
        end else begin
          cyc_cnt <= cyc_cnt + CW'(1);
        end
      end else begin
        tx_q <= 1'b1;
      end
    end
  end

endmodule
